// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight destinations: ID stall, forward selects
// and forwarded operands for rs/rt, plus a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [ADDR_W-1:0]       id_rs,
  input  logic [ADDR_W-1:0]       id_rt,
  input  logic                    id_rs_used,
  input  logic                    id_rt_used,
  input  logic                    id_wr_en,
  input  logic [ADDR_W-1:0]       id_wr_addr,
  input  logic                    id_is_load,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       reg_a,
  input  logic [DATA_W-1:0]       reg_b,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  output logic                    stall,
  output logic [SEL_W-1:0]        fwd_sel_a,
  output logic [SEL_W-1:0]        fwd_sel_b,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output logic [31:0]             stall_cnt
);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] waddr;
    logic              ld;
  } ent_t;

  ent_t              ent_q [DEPTH];
  ent_t              ent_d [DEPTH];
  logic [31:0]       cnt_q;
  logic [31:0]       cnt_d;

  logic [ADDR_W-1:0] src  [2];
  logic [1:0]        used;
  logic [1:0]        hit;
  logic [1:0]        avl;
  logic [SEL_W-1:0]  kk   [2];
  logic [DATA_W-1:0] dat  [2];
  logic              ins;

  assign src[0]  = id_rs;
  assign src[1]  = id_rt;
  assign used[0] = id_rs_used;
  assign used[1] = id_rt_used;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s] = 1'b0;
      avl[s] = 1'b0;
      kk[s]  = '0;
      dat[s] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_q[k].v && (ent_q[k].waddr != '0) &&
            (ent_q[k].waddr == src[s]) && used[s]) begin
          hit[s] = 1'b1;
          kk[s]  = SEL_W'(k + 1);
          avl[s] = ent_q[k].ld ? (k >= LOAD_LAT) : (k >= ALU_LAT);
          dat[s] = stage_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign fwd_sel_a = (hit[0] & avl[0]) ? kk[0] : '0;
  assign fwd_sel_b = (hit[1] & avl[1]) ? kk[1] : '0;
  assign op_a      = (hit[0] & avl[0]) ? dat[0] : reg_a;
  assign op_b      = (hit[1] & avl[1]) ? dat[1] : reg_b;

  assign stall = id_valid & ~flush &
                 ((hit[0] & ~avl[0]) | (hit[1] & ~avl[1]));
  assign ins   = id_valid & ~stall & ~flush;

  always_comb begin
    ent_d[0] = '0;
    if (ins) ent_d[0] = {id_wr_en, id_wr_addr, id_is_load};
    for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: DEPTH=3 and DEPTH=5 instances against
// a cycle-history model of in-flight instructions.
module tb_hazard_scoreboard;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_valid, id_rs_used, id_rt_used;
  logic         id_wr_en, id_is_load, flush;
  logic [4:0]   id_rs, id_rt, id_wr_addr;
  logic [31:0]  reg_a, reg_b;
  logic [95:0]  sd3;
  logic [159:0] sd5;

  logic         st3, st5;
  logic [1:0]   sa3, sb3;
  logic [2:0]   sa5, sb5;
  logic [31:0]  oa3, ob3, oa5, ob5, cnt3, cnt5;

  always #5 clk = ~clk;

  hazard_scoreboard u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .flush(flush),
    .reg_a(reg_a), .reg_b(reg_b), .stage_data(sd3),
    .stall(st3), .fwd_sel_a(sa3), .fwd_sel_b(sb3),
    .op_a(oa3), .op_b(ob3), .stall_cnt(cnt3)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(3)) u5 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .flush(flush),
    .reg_a(reg_a), .reg_b(reg_b), .stage_data(sd5),
    .stall(st5), .fwd_sel_a(sa5), .fwd_sel_b(sb5),
    .op_a(oa5), .op_b(ob5), .stall_cnt(cnt5)
  );

  localparam int NC = 2048;

  // Per-instance history: what was accepted into EX at the end of cycle c.
  logic       hv [2][NC];
  logic [4:0] ha [2][NC];
  logic       hl [2][NC];
  int         cyc, rbase;
  int         cnt [2];
  logic       mst [2];
  int         n_ass, n_fail;

  function automatic int dep(input int i);
    return (i == 0) ? 3 : 5;
  endfunction

  function automatic int llat(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic logic [31:0] sdat(input int i, input int k);
    if (i == 0) return sd3[k*32 +: 32];
    return sd5[k*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_ass++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Age j instruction = the one accepted j+1 cycles ago.
  task automatic lookup(input int i, input logic [4:0] src,
                        input logic used, output int k, output logic av);
    int idx;
    k  = -1;
    av = 1'b0;
    for (int j = 0; j < dep(i); j++) begin
      idx = cyc - 1 - j;
      if (k < 0 && idx >= 0 && idx >= rbase && used && src != 5'd0) begin
        if (hv[i][idx] && ha[i][idx] == src) begin
          k  = j;
          av = hl[i][idx] ? (j >= llat(i)) : (j >= 1);
        end
      end
    end
  endtask

  task automatic setin(input logic v, input int rs, input logic rsu,
                       input int rt, input logic rtu, input logic we,
                       input int wa, input logic ld, input logic fl);
    id_valid   = v;
    id_rs      = 5'(rs);
    id_rs_used = rsu;
    id_rt      = 5'(rt);
    id_rt_used = rtu;
    id_wr_en   = we;
    id_wr_addr = 5'(wa);
    id_is_load = ld;
    flush      = fl;
    reg_a      = $urandom;
    reg_b      = $urandom;
    sd3        = {$urandom, $urandom, $urandom};
    sd5        = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic eval_check();
    int ka, kb;
    logic aa, ab, hz, st;
    logic [31:0] esa, esb, eoa, eob;
    #3;
    if (!rst) begin
      rbase  = cyc;
      cnt[0] = 0;
      cnt[1] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      lookup(i, id_rs, id_rs_used, ka, aa);
      lookup(i, id_rt, id_rt_used, kb, ab);
      hz     = (ka >= 0 && !aa) || (kb >= 0 && !ab);
      st     = id_valid && hz && !flush;
      mst[i] = st;
      esa    = (ka >= 0 && aa) ? 32'(ka + 1) : 32'd0;
      esb    = (kb >= 0 && ab) ? 32'(kb + 1) : 32'd0;
      eoa    = (ka >= 0 && aa) ? sdat(i, ka) : reg_a;
      eob    = (kb >= 0 && ab) ? sdat(i, kb) : reg_b;
      if (i == 0) begin
        chk("d3_stall", 32'(st3), 32'(st));
        chk("d3_sel_a", 32'(sa3), esa);
        chk("d3_sel_b", 32'(sb3), esb);
        chk("d3_op_a", oa3, eoa);
        chk("d3_op_b", ob3, eob);
        chk("d3_cnt", cnt3, 32'(cnt[0]));
      end else begin
        chk("d5_stall", 32'(st5), 32'(st));
        chk("d5_sel_a", 32'(sa5), esa);
        chk("d5_sel_b", 32'(sb5), esb);
        chk("d5_op_a", oa5, eoa);
        chk("d5_op_b", ob5, eob);
        chk("d5_cnt", cnt5, 32'(cnt[1]));
      end
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      hv[i][cyc] = rst && id_valid && !mst[i] && !flush && id_wr_en;
      ha[i][cyc] = id_wr_addr;
      hl[i][cyc] = id_is_load;
      if (rst && mst[i]) cnt[i]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    eval_check();
    advance();
    rst = 1'b1;
  endtask

  // Reset asserted mid-cycle, after the current outputs were checked.
  task automatic mid_reset();
    rst = 1'b0;
    #1;
    chk("rst_stall_d3", 32'(st3), 32'd0);
    chk("rst_stall_d5", 32'(st5), 32'd0);
    chk("rst_cnt_d3", cnt3, 32'd0);
    chk("rst_cnt_d5", cnt5, 32'd0);
    rbase  = cyc;
    cnt[0] = 0;
    cnt[1] = 0;
    advance();
    rst = 1'b1;
  endtask

  initial begin
    n_ass  = 0;
    n_fail = 0;
    cyc    = 0;
    rbase  = 0;
    cnt[0] = 0;
    cnt[1] = 0;
    rst    = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    do_reset();

    // Empty scoreboard: regfile operands pass through.
    setin(1, 5, 1, 6, 1, 0, 0, 0, 0);
    eval_check();
    chk("empty_stall", 32'(st3), 32'd0);
    chk("empty_sel_a", 32'(sa3), 32'd0);
    chk("empty_sel_b", 32'(sb3), 32'd0);
    chk("empty_op_a", oa3, reg_a);
    chk("empty_op_b", ob3, reg_b);
    advance();

    // ALU result: one stall, then forward from entry 1.
    do_reset();
    setin(1, 0, 0, 0, 0, 1, 8, 0, 0);
    eval_check(); advance();
    setin(1, 8, 1, 0, 0, 0, 0, 0, 0);
    eval_check();
    chk("alu_stall_d3", 32'(st3), 32'd1);
    chk("alu_stall_d5", 32'(st5), 32'd1);
    advance();
    setin(1, 8, 1, 0, 0, 0, 0, 0, 0);
    eval_check();
    chk("alu_fwd_stall", 32'(st3), 32'd0);
    chk("alu_fwd_sel", 32'(sa3), 32'd2);
    chk("alu_fwd_op", oa3, sd3[63:32]);
    chk("alu_fwd_sel_d5", 32'(sa5), 32'd2);
    chk("alu_cnt", cnt3, 32'd1);
    advance();

    // Load: 2 stalls at DEPTH=3, 3 stalls at DEPTH=5/LOAD_LAT=3.
    do_reset();
    setin(1, 0, 0, 0, 0, 1, 9, 1, 0);
    eval_check(); advance();
    for (int c = 0; c < 2; c++) begin
      setin(1, 0, 0, 9, 1, 0, 0, 0, 0);
      eval_check();
      chk("ld_stall_d3", 32'(st3), 32'd1);
      chk("ld_stall_d5", 32'(st5), 32'd1);
      advance();
    end
    setin(1, 0, 0, 9, 1, 0, 0, 0, 0);
    eval_check();
    chk("ld_fwd_stall_d3", 32'(st3), 32'd0);
    chk("ld_fwd_sel_d3", 32'(sb3), 32'd3);
    chk("ld_fwd_op_d3", ob3, sd3[95:64]);
    chk("ld_cnt_d3", cnt3, 32'd2);
    chk("ld_stall3_d5", 32'(st5), 32'd1);
    advance();
    setin(1, 0, 0, 9, 1, 0, 0, 0, 0);
    eval_check();
    chk("ld_fwd_stall_d5", 32'(st5), 32'd0);
    chk("ld_fwd_sel_d5", 32'(sb5), 32'd4);
    chk("ld_fwd_op_d5", ob5, sd5[127:96]);
    chk("ld_cnt_d5", cnt5, 32'd3);
    advance();

    // Youngest of two matches wins; $0 never matches.
    do_reset();
    setin(1, 0, 0, 0, 0, 1, 4, 0, 0); eval_check(); advance();
    setin(1, 0, 0, 0, 0, 1, 4, 0, 0); eval_check(); advance();
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0); eval_check(); advance();
    setin(1, 4, 1, 0, 0, 0, 0, 0, 0);
    eval_check();
    chk("young_sel", 32'(sa3), 32'd2);
    chk("young_stall", 32'(st3), 32'd0);
    chk("young_sel_d5", 32'(sa5), 32'd2);
    advance();
    setin(1, 0, 0, 0, 0, 1, 0, 0, 0); eval_check(); advance();
    setin(1, 0, 0, 0, 0, 1, 0, 1, 0); eval_check(); advance();
    setin(1, 0, 1, 0, 1, 0, 0, 0, 0);
    eval_check();
    chk("r0_sel_a", 32'(sa3), 32'd0);
    chk("r0_stall", 32'(st3), 32'd0);
    advance();

    // Flush beats a hazard and inserts nothing.
    do_reset();
    setin(1, 0, 0, 0, 0, 1, 8, 0, 0); eval_check(); advance();
    setin(1, 8, 1, 0, 0, 1, 10, 0, 1);
    eval_check();
    chk("flush_stall_d3", 32'(st3), 32'd0);
    chk("flush_stall_d5", 32'(st5), 32'd0);
    advance();
    setin(1, 10, 1, 8, 1, 0, 0, 0, 0);
    eval_check();
    chk("flush_bubble_stall", 32'(st3), 32'd0);
    chk("flush_bubble_sel_a", 32'(sa3), 32'd0);
    chk("flush_old_sel_b", 32'(sb3), 32'd2);
    chk("flush_cnt", cnt3, 32'd0);
    advance();

    // Reset pulled low while stalling with a nonzero counter.
    setin(1, 0, 0, 0, 0, 1, 8, 0, 0); eval_check(); advance();
    setin(1, 8, 1, 0, 0, 0, 0, 0, 0); eval_check(); advance();
    setin(1, 0, 0, 0, 0, 1, 9, 1, 0); eval_check(); advance();
    setin(1, 0, 0, 9, 1, 0, 0, 0, 0);
    eval_check();
    chk("pre_rst_stall", 32'(st3), 32'd1);
    chk("pre_rst_cnt", cnt3, 32'd1);
    mid_reset();
    setin(1, 0, 0, 9, 1, 0, 0, 0, 0);
    eval_check();
    chk("post_rst_stall", 32'(st3), 32'd0);
    chk("post_rst_sel_b", 32'(sb3), 32'd0);
    advance();

    // Random traffic over a small register set.
    for (int n = 0; n < 1000; n++) begin
      setin(($urandom_range(0, 7) != 0),
            $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      eval_check();
      if ($urandom_range(0, 149) == 0) mid_reset();
      else advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_ass, n_fail);
    $finish;
  end

endmodule
